// File: rtl/lcd4_pkg.sv
// Shared types, default 27 MHz timing and helpers for the 4-bit HD44780 sequencer.
package lcd4_pkg;

    localparam int unsigned WAIT_W = 20;

    localparam int unsigned DEF_FIFO_DEPTH     = 8;
    localparam int unsigned DEF_TAS_CYC        = 2;
    localparam int unsigned DEF_TPW_CYC        = 13;
    localparam int unsigned DEF_TH_CYC         = 2;
    localparam int unsigned DEF_CMD_WAIT_CYC   = 1080;
    localparam int unsigned DEF_CLR_WAIT_CYC   = 44280;
    localparam int unsigned DEF_PON_WAIT_CYC   = 405000;
    localparam int unsigned DEF_INIT1_WAIT_CYC = 110700;
    localparam int unsigned DEF_INIT2_WAIT_CYC = 2700;

    typedef enum logic [3:0] {
        StPonWait,
        StInitSetup,
        StInitE,
        StInitHold,
        StInitWait,
        StIdle,
        StSetup,
        StEHigh,
        StHold,
        StExecWait
    } lcd_state_t;

    // Counter value loaded on state entry so the state lasts exactly cyc cycles.
    function automatic logic [WAIT_W-1:0] wait_load(input int unsigned cyc);
        return (cyc == 0) ? '0 : WAIT_W'(cyc - 1);
    endfunction

    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // Clear display and return home need the long execution time.
    function automatic logic slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd4_ctrl_if.sv
// CPU-side write port of the LCD sequencer: {rs, byte} push with ready.
interface lcd4_ctrl_if;

    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);

endinterface

// File: rtl/lcd4_fifo.sv
// Synchronous FIFO with registered occupancy; full blocks pushes even on a same-cycle pop.
module lcd4_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o     = (level_q == LVL_W'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/lcd4_ctrl.sv
// HD44780 4-bit sequencer: power-on init, then drains the write FIFO two nibbles per byte.
module lcd4_ctrl
    import lcd4_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int unsigned TAS_CYC        = DEF_TAS_CYC,
    parameter int unsigned TPW_CYC        = DEF_TPW_CYC,
    parameter int unsigned TH_CYC         = DEF_TH_CYC,
    parameter int unsigned CMD_WAIT_CYC   = DEF_CMD_WAIT_CYC,
    parameter int unsigned CLR_WAIT_CYC   = DEF_CLR_WAIT_CYC,
    parameter int unsigned PON_WAIT_CYC   = DEF_PON_WAIT_CYC,
    parameter int unsigned INIT1_WAIT_CYC = DEF_INIT1_WAIT_CYC,
    parameter int unsigned INIT2_WAIT_CYC = DEF_INIT2_WAIT_CYC
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    lcd4_ctrl_if.slave                    wr_if,
    output logic                          busy_o,
    output logic                          init_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          lcd_e_o,
    output logic                          lcd_rw_o,
    output logic                          lcd_rs_o,
    output logic [3:0]                    lcd_db_o
);

    localparam logic [WAIT_W-1:0] TAS_LD   = wait_load(TAS_CYC);
    localparam logic [WAIT_W-1:0] TPW_LD   = wait_load(TPW_CYC);
    localparam logic [WAIT_W-1:0] TH_LD    = wait_load(TH_CYC);
    localparam logic [WAIT_W-1:0] CMD_LD   = wait_load(CMD_WAIT_CYC);
    localparam logic [WAIT_W-1:0] CLR_LD   = wait_load(CLR_WAIT_CYC);
    localparam logic [WAIT_W-1:0] PON_LD   = wait_load(PON_WAIT_CYC);
    localparam logic [WAIT_W-1:0] INIT1_LD = wait_load(INIT1_WAIT_CYC);
    localparam logic [WAIT_W-1:0] INIT2_LD = wait_load(INIT2_WAIT_CYC);

    lcd_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        init_idx_q, init_idx_d;
    logic              init_done_q, init_done_d;
    logic [8:0]        byte_q, byte_d;
    logic              nib_lo_q, nib_lo_d;
    logic              e_q, e_d;
    logic              rs_q, rs_d;
    logic [3:0]        db_q, db_d;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [8:0]        fifo_rdata;
    logic              wait_zero;

    lcd4_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .push_i      (wr_if.wr_valid),
        .push_data_i ({wr_if.wr_rs, wr_if.wr_data}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level_o)
    );

    assign wait_zero = (wait_q == '0);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_zero ? '0 : wait_q - 1'b1;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        byte_d      = byte_q;
        nib_lo_d    = nib_lo_q;
        e_d         = e_q;
        rs_d        = rs_q;
        db_d        = db_q;
        fifo_pop    = 1'b0;

        case (state_q)
            StPonWait: if (wait_zero) begin
                state_d = StInitSetup;
                wait_d  = TAS_LD;
                rs_d    = 1'b0;
                db_d    = init_nibble(init_idx_q);
            end
            StInitSetup: if (wait_zero) begin
                state_d = StInitE;
                wait_d  = TPW_LD;
                e_d     = 1'b1;
            end
            StInitE: if (wait_zero) begin
                state_d = StInitHold;
                wait_d  = TH_LD;
                e_d     = 1'b0;
            end
            StInitHold: if (wait_zero) begin
                state_d = StInitWait;
                case (init_idx_q)
                    2'd0:    wait_d = INIT1_LD;
                    2'd1:    wait_d = INIT2_LD;
                    default: wait_d = CMD_LD;
                endcase
            end
            StInitWait: if (wait_zero) begin
                if (init_idx_q == 2'd3) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end else begin
                    state_d    = StInitSetup;
                    wait_d     = TAS_LD;
                    init_idx_d = init_idx_q + 2'd1;
                    db_d       = init_nibble(init_idx_q + 2'd1);
                end
            end
            StIdle: if (!fifo_empty) begin
                fifo_pop = 1'b1;
                byte_d   = fifo_rdata;
                rs_d     = fifo_rdata[8];
                db_d     = fifo_rdata[7:4];
                nib_lo_d = 1'b0;
                state_d  = StSetup;
                wait_d   = TAS_LD;
            end
            StSetup: if (wait_zero) begin
                state_d = StEHigh;
                wait_d  = TPW_LD;
                e_d     = 1'b1;
            end
            StEHigh: if (wait_zero) begin
                state_d = StHold;
                wait_d  = TH_LD;
                e_d     = 1'b0;
            end
            StHold: if (wait_zero) begin
                if (!nib_lo_q) begin
                    db_d     = byte_q[3:0];
                    nib_lo_d = 1'b1;
                    state_d  = StSetup;
                    wait_d   = TAS_LD;
                end else begin
                    state_d = StExecWait;
                    wait_d  = slow_cmd(byte_q[8], byte_q[7:0]) ? CLR_LD : CMD_LD;
                end
            end
            StExecWait: if (wait_zero) state_d = StIdle;
            default: begin
                state_d = StPonWait;
                wait_d  = PON_LD;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPonWait;
            wait_q      <= PON_LD;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            byte_q      <= '0;
            nib_lo_q    <= 1'b0;
            e_q         <= 1'b0;
            rs_q        <= 1'b0;
            db_q        <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            byte_q      <= byte_d;
            nib_lo_q    <= nib_lo_d;
            e_q         <= e_d;
            rs_q        <= rs_d;
            db_q        <= db_d;
        end
    end

    assign wr_if.wr_ready = !fifo_full;
    assign busy_o         = !init_done_q || !fifo_empty || (state_q != StIdle);
    assign init_done_o    = init_done_q;
    assign lcd_e_o        = e_q;
    assign lcd_rw_o       = 1'b0;
    assign lcd_rs_o       = rs_q;
    assign lcd_db_o       = db_q;

endmodule

// File: tb/tb_lcd4_ctrl.sv
// Bench for lcd4_ctrl: records E pulses and compares them with a nibble/timing model.
module tb_lcd4_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int TAS = 1, TPW = 3, TH = 1, CMD = 10, CLR = 50;
    localparam int PON = 20, INIT1 = 15, INIT2 = 8;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       busy, init_done, lcd_e, lcd_rw, lcd_rs;
    logic [3:0] lcd_db;
    logic [3:0] fifo_level;

    lcd4_ctrl_if wr_if ();

    lcd4_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TAS_CYC        (TAS),
        .TPW_CYC        (TPW),
        .TH_CYC         (TH),
        .CMD_WAIT_CYC   (CMD),
        .CLR_WAIT_CYC   (CLR),
        .PON_WAIT_CYC   (PON),
        .INIT1_WAIT_CYC (INIT1),
        .INIT2_WAIT_CYC (INIT2)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .wr_if        (wr_if),
        .busy_o       (busy),
        .init_done_o  (init_done),
        .fifo_level_o (fifo_level),
        .lcd_e_o      (lcd_e),
        .lcd_rw_o     (lcd_rw),
        .lcd_rs_o     (lcd_rs),
        .lcd_db_o     (lcd_db)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { bit rs; logic [3:0] db; int rise; int fall; bit ok; } pulse_t;
    typedef struct { bit rs; logic [3:0] db; int gmin; int gmax; } exp_t;

    pulse_t pulses[$];
    exp_t   exp_q[$];
    int     total = 0, bad = 0;
    int     cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Pulse recorder: sampled on the falling clock edge, away from register updates.
    bit         in_pulse = 1'b0, cur_rs = 1'b0, cur_ok = 1'b0, rw_bad = 1'b0;
    logic       busy_prev = 1'b1;
    logic [3:0] cur_db = '0;
    int         cur_rise = 0, n_fall = 0, busy_fall_cyc = 0;

    always @(negedge sys_clk) begin
        if (lcd_rw !== 1'b0) rw_bad <= 1'b1;
        busy_prev <= busy;
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc <= cyc;
        if (!rst_n) begin
            in_pulse <= 1'b0;
        end else if (!in_pulse && lcd_e === 1'b1) begin
            in_pulse <= 1'b1;
            cur_rise <= cyc;
            cur_rs   <= lcd_rs;
            cur_db   <= lcd_db;
            cur_ok   <= 1'b1;
        end else if (in_pulse && lcd_e !== 1'b1) begin
            in_pulse <= 1'b0;
            pulses.push_back('{rs: cur_rs, db: cur_db, rise: cur_rise, fall: cyc, ok: cur_ok});
            n_fall <= n_fall + 1;
        end else if (in_pulse && (lcd_rs !== cur_rs || lcd_db !== cur_db)) begin
            cur_ok <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference model: expected nibbles and the E-fall to next-E-rise gap.
    int model_gap  = 0;
    bit model_open = 1'b0;
    int last_fall  = 0;

    function automatic int exec_wait(input bit rs, input logic [7:0] d);
        return (!rs && d < 8'h04) ? CLR : CMD;
    endfunction

    task automatic add_nib(input bit rs, input logic [3:0] db);
        exp_q.push_back('{rs: rs, db: db, gmin: model_gap - 2,
                          gmax: model_open ? 32'h7fffffff : model_gap + 2});
        model_open = 1'b0;
    endtask

    task automatic add_byte(input bit rs, input logic [7:0] d);
        add_nib(rs, d[7:4]);
        model_gap = TH + TAS;
        add_nib(rs, d[3:0]);
        model_gap = TH + exec_wait(rs, d) + 1 + TAS;
    endtask

    task automatic add_init();
        model_open = 1'b0;
        model_gap  = PON + TAS;
        add_nib(1'b0, 4'h3);
        model_gap = TH + INIT1 + TAS;
        add_nib(1'b0, 4'h3);
        model_gap = TH + INIT2 + TAS;
        add_nib(1'b0, 4'h3);
        model_gap = TH + CMD + TAS;
        add_nib(1'b0, 4'h2);
        model_gap = TH + CMD + 1 + TAS;
    endtask

    task automatic check_pulses(input string tag);
        pulse_t p;
        exp_t   w;
        int     n;
        chk({tag, "_count"}, pulses.size(), exp_q.size());
        n = (pulses.size() < exp_q.size()) ? pulses.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            p = pulses.pop_front();
            w = exp_q.pop_front();
            chk($sformatf("%s_%0d_rs", tag, i), p.rs, w.rs);
            chk($sformatf("%s_%0d_db", tag, i), p.db, w.db);
            chk($sformatf("%s_%0d_width", tag, i), p.fall - p.rise, TPW);
            chk($sformatf("%s_%0d_stable", tag, i), p.ok, 1);
            chk_rng($sformatf("%s_%0d_gap", tag, i), p.rise - last_fall, w.gmin, w.gmax);
            last_fall = p.fall;
        end
        pulses.delete();
        exp_q.delete();
    endtask

    task automatic wait_init(input int budget, output int seen);
        int k = 0;
        while (init_done !== 1'b1 && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        seen = cyc;
        chk("init_done_timeout", init_done, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        chk({tag, "_idle_timeout"}, busy, 0);
        @(negedge sys_clk);
    endtask

    task automatic push(input bit rs, input logic [7:0] d);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_rs    = rs;
        wr_if.wr_data  = d;
        @(negedge sys_clk);
    endtask

    function automatic logic [7:0] rnd_byte();
        return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
    endfunction

    bit         rs_a [9];
    logic [7:0] d_a  [9];
    int         id_cyc, lo_fall, base, target, k;
    bit         xrs;
    logic [7:0] xd;

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_rs    = 1'b0;
        wr_if.wr_data  = '0;
        repeat (3) @(negedge sys_clk);

        chk("rst_e", lcd_e, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_db", lcd_db, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ready", wr_if.wr_ready, 1);
        chk("rst_level", fifo_level, 0);

        // Release, then fill the FIFO during init; the ninth push must stall.
        rst_n = 1'b1;
        last_fall = cyc;
        add_init();
        for (int i = 0; i < 9; i++) begin
            rs_a[i] = 1'($urandom_range(0, 1));
            d_a[i]  = rnd_byte();
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("burst_ready_%0d", i), wr_if.wr_ready, 1);
            push(rs_a[i], d_a[i]);
        end
        wr_if.wr_rs   = rs_a[8];
        wr_if.wr_data = d_a[8];
        chk("full_ready", wr_if.wr_ready, 0);
        chk("full_level", fifo_level, 8);
        @(negedge sys_clk);
        chk("held_level", fifo_level, 8);
        chk("held_busy", busy, 1);

        wait_init(600, id_cyc);
        @(negedge sys_clk);
        check_pulses("init");
        chk_rng("init_done_time", id_cyc - last_fall, TH + CMD - 2, TH + CMD + 2);
        // First pop with FIFO full: the held push is refused that cycle.
        chk("pop_reject_level", fifo_level, 7);
        chk("pop_reject_ready", wr_if.wr_ready, 1);
        @(negedge sys_clk);
        chk("late_push_level", fifo_level, 8);
        wr_if.wr_valid = 1'b0;
        for (int i = 0; i < 9; i++) add_byte(rs_a[i], d_a[i]);
        wait_idle(3000, "burst");
        check_pulses("burst");

        // Single data byte 0x41 and the busy release after its execution time.
        model_open = 1'b1;
        push(1'b1, 8'h41);
        wr_if.wr_valid = 1'b0;
        add_byte(1'b1, 8'h41);
        wait_idle(200, "data41");
        lo_fall = (pulses.size() > 0) ? pulses[pulses.size() - 1].fall : 0;
        chk_rng("busy_drop", busy_fall_cyc - lo_fall, TH + CMD - 2, TH + CMD + 2);
        check_pulses("data41");

        // Clear display followed at once by another byte: long wait in between.
        model_open = 1'b1;
        xrs = 1'($urandom_range(0, 1));
        xd  = rnd_byte();
        push(1'b0, 8'h01);
        push(xrs, xd);
        wr_if.wr_valid = 1'b0;
        add_byte(1'b0, 8'h01);
        add_byte(xrs, xd);
        wait_idle(400, "clr");
        check_pulses("clr");

        // Push exactly on the pop cycle with three entries queued.
        model_open = 1'b1;
        base = n_fall;
        xd = 8'($urandom);
        push(1'b1, xd);
        add_byte(1'b1, xd);
        for (int i = 0; i < 4; i++) begin
            rs_a[i] = 1'($urandom_range(0, 1));
            d_a[i]  = rnd_byte();
        end
        for (int i = 0; i < 3; i++) push(rs_a[i], d_a[i]);
        wr_if.wr_valid = 1'b0;
        k = 0;
        while (n_fall < base + 2 && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        chk("lvl3_fall_timeout", n_fall >= base + 2, 1);
        lo_fall = (pulses.size() >= 2) ? pulses[1].fall : cyc;
        target = lo_fall + TH + CMD;
        k = 0;
        while (cyc < target && k < 100) begin
            @(negedge sys_clk);
            k++;
        end
        chk("lvl3_pre_level", fifo_level, 3);
        push(rs_a[3], d_a[3]);
        wr_if.wr_valid = 1'b0;
        chk("lvl3_pushpop_level", fifo_level, 3);
        for (int i = 0; i < 4; i++) add_byte(rs_a[i], d_a[i]);
        wait_idle(1000, "lvl3");
        check_pulses("lvl3");

        // Reset while E is high for a data byte, then the whole init reruns.
        push(1'b1, 8'($urandom));
        push(1'b1, 8'($urandom));
        push(1'b0, 8'h80);
        wr_if.wr_valid = 1'b0;
        k = 0;
        while (lcd_e !== 1'b1 && k < 50) begin
            @(negedge sys_clk);
            k++;
        end
        chk("ehigh_seen", lcd_e, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_e", lcd_e, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_ready", wr_if.wr_ready, 1);
        chk("mid_rst_db", lcd_db, 0);
        repeat (2) @(negedge sys_clk);
        pulses.delete();
        exp_q.delete();
        rst_n = 1'b1;
        last_fall = cyc;
        add_init();
        wait_init(600, id_cyc);
        @(negedge sys_clk);
        check_pulses("reinit");
        chk("reinit_busy", busy, 0);
        chk("reinit_level", fifo_level, 0);
        chk("rw_always_low", rw_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
